// File: rtl/plab4_net_router_input_terminal_ctrl_wh_if.sv
// plab4_net_router_input_terminal_ctrl_wh_if: flit, credit and arbitration signals of the terminal input controller
interface plab4_net_router_input_terminal_ctrl_wh_if #(
   parameter int p_num_routers    = 8,
   parameter int p_num_free_nbits = 2,
   parameter int p_len_nbits      = 4,
   parameter int p_cnt_nbits      = 16
);
   localparam int c_dest_nbits = $clog2(p_num_routers);
   logic [c_dest_nbits-1:0]     dest;
   logic [p_len_nbits-1:0]      len;
   logic                        in_val;
   logic                        in_rdy;
   logic [p_num_free_nbits-1:0] num_free_prev;
   logic [p_num_free_nbits-1:0] num_free_next;
   logic [2:0]                  reqs;
   logic [2:0]                  grants;
   logic                        locked;
   logic [p_cnt_nbits-1:0]      pkt_count;
   modport master (
      output dest, len, in_val, num_free_prev, num_free_next, grants,
      input  in_rdy, reqs, locked, pkt_count
   );
   modport slave (
      input  dest, len, in_val, num_free_prev, num_free_next, grants,
      output in_rdy, reqs, locked, pkt_count
   );
endinterface

// File: rtl/plab4_net_router_input_terminal_ctrl_wh.sv
// plab4_net_router_input_terminal_ctrl_wh: wormhole terminal input controller with greedy ring routing,
// bubble flow control on head flits and an output lock held until the tail flit leaves.
module plab4_net_router_input_terminal_ctrl_wh #(
   parameter int p_router_id      = 0,
   parameter int p_num_routers    = 8,
   parameter int p_num_free_nbits = 2,
   parameter int p_bubble         = 2,
   parameter int p_len_nbits      = 4,
   parameter int p_cnt_nbits      = 16
) (
   input logic clk,
   input logic reset,
   plab4_net_router_input_terminal_ctrl_wh_if.slave bus
);
   localparam int c_dest_nbits = $clog2(p_num_routers);
   localparam logic [c_dest_nbits:0] c_n    = (c_dest_nbits+1)'(p_num_routers);
   localparam logic [c_dest_nbits:0] c_id   = (c_dest_nbits+1)'(p_router_id);
   localparam logic [c_dest_nbits:0] c_half = (c_dest_nbits+1)'(p_num_routers / 2);

   typedef enum logic {IDLE, BODY} state_t;

   state_t                 r_state;
   logic [2:0]             r_route;
   logic [p_len_nbits-1:0] r_rem;
   logic                   r_locked;
   logic [p_cnt_nbits-1:0] r_cnt;

   logic [c_dest_nbits:0] w_sum;
   logic [c_dest_nbits:0] w_d;
   logic [2:0]            w_route;
   logic [2:0]            w_port;
   logic [2:0]            w_reqs;
   logic [31:0]           w_need;
   logic                  w_ok;
   logic                  w_xfer;

   // Head flits need the full bubble on a ring port; body flits only need one slot.
   always_comb begin
      w_sum   = {1'b0, bus.dest} + c_n - c_id;
      w_d     = (w_sum >= c_n) ? w_sum - c_n : w_sum;
      w_route = (w_d == '0) ? 3'b010 : (w_d <= c_half) ? 3'b100 : 3'b001;
      w_port  = (r_state == IDLE) ? w_route : r_route;
      w_need  = (r_state == IDLE) ? 32'(p_bubble) : 32'd1;
      w_ok    = w_port[1]
              | (w_port[0] & (32'(bus.num_free_prev) >= w_need))
              | (w_port[2] & (32'(bus.num_free_next) >= w_need));
      w_reqs  = (reset && bus.in_val && w_ok) ? w_port : 3'b000;
      w_xfer  = |(w_reqs & bus.grants);
   end

   assign bus.reqs      = w_reqs;
   assign bus.in_rdy    = w_xfer;
   assign bus.locked    = r_locked;
   assign bus.pkt_count = r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_route  <= 3'b000;
         r_rem    <= '0;
         r_locked <= 1'b0;
         r_cnt    <= '0;
      end else if (w_xfer) begin
         if (r_state == IDLE) begin
            if (bus.len == '0) begin
               r_cnt <= r_cnt + p_cnt_nbits'(1);
            end else begin
               r_state  <= BODY;
               r_route  <= w_route;
               r_rem    <= bus.len;
               r_locked <= 1'b1;
            end
         end else begin
            r_rem <= r_rem - p_len_nbits'(1);
            if (r_rem == p_len_nbits'(1)) begin
               r_state  <= IDLE;
               r_locked <= 1'b0;
               r_cnt    <= r_cnt + p_cnt_nbits'(1);
            end
         end
      end
   end
endmodule
